// File: rtl/imu_sample_fifo_if.sv
// Sample-stream bundle for imu_sample_fifo: sensor-side push, Madgwick-side
// valid/ready pop, and the flush / overflow status signals.
// slave = the FIFO itself, master = the surrounding logic driving it.
interface imu_sample_fifo_if #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned GYRO_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned DATA_W = 3 * ACC_W + 3 * GYRO_W;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              flush;
  logic              clr_ovf;
  logic [LVL_W-1:0]  level;
  logic              ovf;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output s_valid, s_data, m_ready, flush, clr_ovf,
    input  m_valid, m_data, level, ovf, drop_cnt
  );

  modport slave (
    input  s_valid, s_data, m_ready, flush, clr_ovf,
    output m_valid, m_data, level, ovf, drop_cnt
  );
endinterface

// File: rtl/imu_sample_fifo.sv
// imu_sample_fifo: buffers 6-axis IMU samples ahead of the Madgwick core.
// The sensor side cannot be stalled; samples arriving while full are dropped
// and counted. The head is presented first-word-fall-through from a register.
// Optional macro IMU_DECIM_EN adds a DECIM-sample boxcar decimator in front.
module imu_sample_fifo #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned GYRO_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DECIM  = 4
) (
  input logic              clk,
  input logic              rst_n,
  imu_sample_fifo_if.slave bus
);
  localparam int unsigned DATA_W = 3 * ACC_W + 3 * GYRO_W;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imu_sample_fifo: DEPTH must be a power of two >= 2");
  end
  if (DECIM < 2 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
    $error("imu_sample_fifo: DECIM must be a power of two >= 2");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              push_ev;
  logic [DATA_W-1:0] push_data;
  logic [PTR_W-1:0]  level;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              drop;

`ifdef IMU_DECIM_EN
  localparam int unsigned DL   = $clog2(DECIM);
  localparam int unsigned AS_W = ACC_W + DL;
  localparam int unsigned GS_W = GYRO_W + DL;

  logic signed [AS_W-1:0] acc_sum_q [3];
  logic signed [AS_W-1:0] acc_sum_d [3];
  logic signed [GS_W-1:0] gyr_sum_q [3];
  logic signed [GS_W-1:0] gyr_sum_d [3];
  logic [DL-1:0]          phase_q, phase_d;
  logic                   dec_valid_q, dec_valid_d;
  logic [DATA_W-1:0]      dec_data_q, dec_data_d;

  // Boxcar accumulate; on the last sample of a window register the mean
  // (arithmetic shift, so rounding is toward -inf) and restart the window.
  always_comb begin
    logic signed [AS_W-1:0] a_tot;
    logic signed [GS_W-1:0] g_tot;
    a_tot       = '0;
    g_tot       = '0;
    acc_sum_d   = acc_sum_q;
    gyr_sum_d   = gyr_sum_q;
    phase_d     = phase_q;
    dec_valid_d = 1'b0;
    dec_data_d  = dec_data_q;
    if (bus.flush) begin
      for (int unsigned i = 0; i < 3; i++) begin
        acc_sum_d[i] = '0;
        gyr_sum_d[i] = '0;
      end
      phase_d = '0;
    end else if (bus.s_valid) begin
      for (int unsigned i = 0; i < 3; i++) begin
        a_tot = acc_sum_q[i] + AS_W'($signed(bus.s_data[i*ACC_W +: ACC_W]));
        g_tot = gyr_sum_q[i] + GS_W'($signed(bus.s_data[3*ACC_W + i*GYRO_W +: GYRO_W]));
        acc_sum_d[i] = a_tot;
        gyr_sum_d[i] = g_tot;
        dec_data_d[i*ACC_W +: ACC_W]            = ACC_W'(a_tot >>> DL);
        dec_data_d[3*ACC_W + i*GYRO_W +: GYRO_W] = GYRO_W'(g_tot >>> DL);
      end
      if (phase_q == DL'(DECIM - 1)) begin
        dec_valid_d = 1'b1;
        phase_d     = '0;
        for (int unsigned i = 0; i < 3; i++) begin
          acc_sum_d[i] = '0;
          gyr_sum_d[i] = '0;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Decimator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        acc_sum_q[i] <= '0;
        gyr_sum_q[i] <= '0;
      end
      phase_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_data_q  <= '0;
    end else begin
      acc_sum_q   <= acc_sum_d;
      gyr_sum_q   <= gyr_sum_d;
      phase_q     <= phase_d;
      dec_valid_q <= dec_valid_d;
      dec_data_q  <= dec_data_d;
    end
  end

  assign push_ev   = dec_valid_q;
  assign push_data = dec_data_q;
`else
  assign push_ev   = bus.s_valid;
  assign push_data = bus.s_data;
`endif

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PTR_W'(DEPTH));
  assign pop   = m_valid_q & bus.m_ready & ~bus.flush;
  assign wr_en = push_ev & ~bus.flush & (~full | pop);
  assign drop  = push_ev & ~bus.flush & full & ~pop;

  // Pointer update and next head. The head register is reloaded from the
  // slot rd_ptr_d names; when that slot is being written this same cycle
  // (push into empty, or push+pop at level 1) the push data is forwarded.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    m_valid_d = (wr_ptr_d != rd_ptr_d);
    m_data_d  = m_data_q;
    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      m_valid_d = 1'b0;
    end else if (m_valid_d) begin
      if (wr_en && (wr_ptr_q[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0])) begin
        m_data_d = push_data;
      end else begin
        m_data_d = mem_q[rd_ptr_d[IDX_W-1:0]];
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats clr_ovf.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (bus.clr_ovf) begin
        drop_cnt_d = CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (bus.clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Sample storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
    end
  end

  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.level    = level;
  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_cnt_q;
endmodule
